// File: rtl/delta_decoder_if.sv
// Valid/ready bundle for the delta decoder: delta/reload beats in, absolute samples out.
// The decoder connects through the slave modport; the producer/consumer side uses master.
interface delta_decoder_if #(
    parameter int DELTA_W = 4,
    parameter int OUT_W   = 8
);
    logic               in_valid;
    logic               in_ready;
    logic               in_load;
    logic [DELTA_W-1:0] in_delta;
    logic [OUT_W-1:0]   in_abs;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_value;
    logic               out_sat;

    modport slave (
        input  in_valid, in_load, in_delta, in_abs, out_ready,
        output in_ready, out_valid, out_value, out_sat
    );

    modport master (
        output in_valid, in_load, in_delta, in_abs, out_ready,
        input  in_ready, out_valid, out_value, out_sat
    );
endinterface

// File: rtl/delta_decoder.sv
// Running-sum delta decoder with optional clamp and a two-entry ping-pong output buffer.
// Every accepted beat updates the accumulator and is queued; the buffer hides downstream stalls.
module delta_decoder #(
    parameter int DELTA_W  = 4,
    parameter int OUT_W    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    delta_decoder_if.slave  bus
);
    localparam int SUM_W = OUT_W + 1;
    localparam logic [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } occ_t;

    typedef struct packed {
        logic [OUT_W-1:0] value;
        logic             sat;
    } entry_t;

    occ_t             state;
    occ_t             state_next;
    logic [OUT_W-1:0] acc;
    entry_t           buf_q [2];
    logic             wp;
    logic             rp;

    logic             accept;
    logic             pop;
    logic [SUM_W-1:0] sum;
    logic [OUT_W-1:0] next_value;
    logic             next_sat;

    // Handshake outputs depend on registered occupancy only, so in_ready never
    // combinationally follows out_ready.
    assign bus.in_ready  = (state != FULL);
    assign bus.out_valid = (state != EMPTY);
    assign bus.out_value = buf_q[rp].value;
    assign bus.out_sat   = buf_q[rp].sat;

    assign accept = bus.in_valid & bus.in_ready;
    assign pop    = bus.out_valid & bus.out_ready;

    // One guard bit makes the sum exact; overflow shows up as the two top bits disagreeing.
    assign sum = {acc[OUT_W-1], acc}
               + {{(SUM_W-DELTA_W){bus.in_delta[DELTA_W-1]}}, bus.in_delta};

    // NOTE: every output of a combinational block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        next_value = sum[OUT_W-1:0];
        next_sat   = 1'b0;
        if (bus.in_load) begin
            next_value = bus.in_abs;
        end else if (SATURATE && (sum[SUM_W-1] != sum[SUM_W-2])) begin
            next_value = sum[SUM_W-1] ? MIN_V : MAX_V;
            next_sat   = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY:   if (accept) state_next = HALF;
            HALF: begin
                if (accept && !pop)      state_next = FULL;
                else if (pop && !accept) state_next = EMPTY;
            end
            FULL:    if (pop) state_next = HALF;
            default: state_next = EMPTY;
        endcase
    end

    // NOTE: sequential state is assigned with non-blocking <= so all registers
    // update together from values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the two buffer entries are reset as well, because the output port shows
    // buf_q[rp] even when empty and must read zero straight after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            wp       <= 1'b0;
            rp       <= 1'b0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            if (accept) begin
                acc       <= next_value;
                buf_q[wp] <= '{value: next_value, sat: next_sat};
                wp        <= ~wp;
            end
            if (pop) begin
                rp <= ~rp;
            end
        end
    end
endmodule

// File: tb/tb_delta_decoder.sv
// Drives a clamping and a wrapping decoder with identical beats and compares both
// against an integer running-sum model with a queue standing in for the buffer.
module tb_delta_decoder;
    localparam int DELTA_W = 4;
    localparam int OUT_W   = 8;
    localparam int MAX_I   = (1 << (OUT_W-1)) - 1;
    localparam int MIN_I   = -(1 << (OUT_W-1));
    localparam int SPAN    = 1 << OUT_W;

    typedef struct {
        int value;
        int sat;
    } sample_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    delta_decoder_if #(.DELTA_W(DELTA_W), .OUT_W(OUT_W)) ifs ();
    delta_decoder_if #(.DELTA_W(DELTA_W), .OUT_W(OUT_W)) ifw ();

    delta_decoder #(.DELTA_W(DELTA_W), .OUT_W(OUT_W), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(ifs.slave)
    );
    delta_decoder #(.DELTA_W(DELTA_W), .OUT_W(OUT_W), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .bus(ifw.slave)
    );

    int errors = 0;
    int checks = 0;

    int      acc_s, acc_w;
    sample_t q_s[$];
    sample_t q_w[$];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic sample_t model_next(input int acc, input bit sat_mode,
                                           input bit load, input int delta, input int abs_v);
        sample_t r;
        int s;
        r.sat = 0;
        if (load) begin
            r.value = abs_v;
        end else begin
            s = acc + delta;
            if (sat_mode && s > MAX_I) begin
                r.value = MAX_I; r.sat = 1;
            end else if (sat_mode && s < MIN_I) begin
                r.value = MIN_I; r.sat = 1;
            end else if (sat_mode) begin
                r.value = s;
            end else begin
                r.value = ((s - MIN_I) % SPAN + SPAN) % SPAN + MIN_I;
            end
        end
        return r;
    endfunction

    task automatic drive(input bit v, input bit load, input int delta, input int abs_v, input bit ordy);
        ifs.in_valid = v;   ifw.in_valid = v;
        ifs.in_load = load; ifw.in_load = load;
        ifs.in_delta = DELTA_W'(delta); ifw.in_delta = DELTA_W'(delta);
        ifs.in_abs = OUT_W'(abs_v);     ifw.in_abs = OUT_W'(abs_v);
        ifs.out_ready = ordy; ifw.out_ready = ordy;
    endtask

    task automatic compare_outputs();
        check("sat.in_ready", int'(ifs.in_ready), int'(q_s.size() != 2));
        check("wrap.in_ready", int'(ifw.in_ready), int'(q_w.size() != 2));
        check("sat.out_valid", int'(ifs.out_valid), int'(q_s.size() != 0));
        check("wrap.out_valid", int'(ifw.out_valid), int'(q_w.size() != 0));
        if (q_s.size() != 0) begin
            check("sat.out_value", int'($signed(ifs.out_value)), q_s[0].value);
            check("sat.out_sat", int'(ifs.out_sat), q_s[0].sat);
        end
        if (q_w.size() != 0) begin
            check("wrap.out_value", int'($signed(ifw.out_value)), q_w[0].value);
            check("wrap.out_sat", int'(ifw.out_sat), q_w[0].sat);
        end
    endtask

    // Called at a falling edge: check current outputs, apply inputs across one rising edge.
    task automatic step(input bit v, input bit load, input int delta, input int abs_v, input bit ordy);
        bit acc_ok, pop_ok;
        sample_t ns, nw;
        drive(v, load, delta, abs_v, ordy);
        #1;
        compare_outputs();
        acc_ok = v && (q_s.size() < 2);
        pop_ok = ordy && (q_s.size() > 0);
        @(posedge clk);
        if (pop_ok) begin
            void'(q_s.pop_front());
            void'(q_w.pop_front());
        end
        if (acc_ok) begin
            ns = model_next(acc_s, 1'b1, load, delta, abs_v);
            nw = model_next(acc_w, 1'b0, load, delta, abs_v);
            acc_s = ns.value;
            acc_w = nw.value;
            q_s.push_back(ns);
            q_w.push_back(nw);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 5, 0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acc_s = 0; acc_w = 0;
        q_s.delete(); q_w.delete();
        drive(1'b0, 1'b0, 0, 0, 1'b0);
        #1;
        compare_outputs();
        check("rst.sat.out_value", int'(ifs.out_value), 0);
        check("rst.sat.out_sat", int'(ifs.out_sat), 0);
        check("rst.wrap.out_value", int'(ifw.out_value), 0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 0, 0, 1'b0);
        @(negedge clk);
        do_reset();

        // Plain running sum, one cycle latency with out_ready high.
        step(1, 0, 3, 0, 1);
        step(1, 0, 3, 0, 1);
        step(1, 0, -7, 0, 1);
        step(1, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1);

        // Positive overflow: clamp vs wrap.
        step(1, 1, 0, 120, 1);
        step(1, 0, 7, 0, 1);
        step(1, 0, 7, 0, 1);
        step(1, 0, -8, 0, 1);
        step(0, 0, 0, 0, 1);

        // Negative overflow.
        step(1, 1, 0, -125, 1);
        step(1, 0, -8, 0, 1);
        step(1, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1);

        // Stall: two beats absorbed, third held until a slot frees.
        do_reset();
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 1);
        step(1, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Randomised valid/ready traffic.
        for (int i = 0; i < 1000; i++) begin
            int r, d, a;
            bit v, ld, rd;
            v  = ($urandom_range(0, 9) < 7);
            ld = ($urandom_range(0, 9) == 0);
            rd = ($urandom_range(0, 9) < 6);
            r  = $urandom_range(0, 15);
            d  = (r >= 8) ? r - 16 : r;
            a  = $urandom_range(0, 255) - 128;
            step(v, ld, d, a, rd);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

        // Reset with two samples buffered drops them; accumulation restarts from zero.
        step(1, 1, 0, 50, 0);
        step(1, 0, 3, 0, 0);
        step(0, 0, 0, 0, 0);
        do_reset();
        step(1, 0, 2, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
